// File: rtl/mem_bank_if.sv
// Request/response bundle between a bus agent and mem_bank_ctrl.
// Latency: none, wires only. The memory side reports readiness on 'ready'.
// Backpressure: the agent must hold requests until ready is high; requests seen while ready is low are dropped.
// Ports (master = agent, slave = memory): addr, wr_en, rd_en, wstrb, wdata go to the memory;
// rdata, rd_valid, ready, addr_err come back. With MEM_PARITY_EN defined, par_inj goes to the
// memory and rd_perr comes back.
interface mem_bank_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0]   addr;
    logic                wr_en;
    logic                rd_en;
    logic [DATA_W/8-1:0] wstrb;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W-1:0]   rdata;
    logic                rd_valid;
    logic                ready;
    logic                addr_err;
`ifdef MEM_PARITY_EN
    logic                par_inj;
    logic [DATA_W/8-1:0] rd_perr;

    modport master (
        output addr, wr_en, rd_en, wstrb, wdata, par_inj,
        input  rdata, rd_valid, ready, addr_err, rd_perr
    );
    modport slave (
        input  addr, wr_en, rd_en, wstrb, wdata, par_inj,
        output rdata, rd_valid, ready, addr_err, rd_perr
    );
`else
    modport master (
        output addr, wr_en, rd_en, wstrb, wdata,
        input  rdata, rd_valid, ready, addr_err
    );
    modport slave (
        input  addr, wr_en, rd_en, wstrb, wdata,
        output rdata, rd_valid, ready, addr_err
    );
`endif
endinterface

// File: rtl/mem_bank_ctrl.sv
// Single-clock memory bank: byte-strobed writes, read-first reads, clear sweep after reset, range check.
// Latency: read data RD_LAT (1 or 2) cycles after acceptance; a write is visible to a read on the next cycle.
// Backpressure: ready is low during the post-reset clear sweep (DEPTH cycles); requests then are dropped.
// Ports: clk, reset (synchronous, active-high), bus (mem_bank_if.slave).
// Optional feature macro: MEM_PARITY_EN adds per-byte even parity, bus.par_inj and bus.rd_perr.
module mem_bank_ctrl #(
    parameter int               DATA_W   = 32,
    parameter int               DEPTH    = 16,
    parameter int               ADDR_W   = $clog2(DEPTH),
    parameter int               RD_LAT   = 1,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic     clk,
    input  logic     reset,
    mem_bank_if.slave bus
);
    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_CMP = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  cnt;
    logic              ready_q;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              in_range;
    logic              acc_wr;
    logic              acc_rd;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] cur_word;
    logic [DATA_W-1:0] wr_word;
    logic [DATA_W-1:0] rd_word;

    logic [DATA_W-1:0] rdata_q;
    logic              rd_valid_q;
    logic              addr_err_q;

`ifdef MEM_PARITY_EN
    // Even parity per byte: the stored bit makes the byte plus parity have an even count of ones.
    function automatic logic [NB-1:0] byte_par(input logic [DATA_W-1:0] d);
        logic [NB-1:0] p;
        p = '0;
        for (int i = 0; i < NB; i++) begin
            p[i] = ^d[8*i +: 8];
        end
        return p;
    endfunction

    localparam logic [NB-1:0] INIT_PAR = byte_par(INIT_VAL);

    logic [NB-1:0] par [DEPTH];
    logic [NB-1:0] cur_par;
    logic [NB-1:0] wr_par;
    logic [NB-1:0] rd_perr_w;
    logic [NB-1:0] rd_perr_q;
`endif

    // Acceptance is qualified by the registered ready, so nothing is taken during the sweep;
    // a request coinciding with reset is dropped as well.
    assign in_range = ({1'b0, bus.addr} < DEPTH_CMP);
    assign acc_wr   = ready_q & ~reset & bus.wr_en;
    assign acc_rd   = ready_q & ~reset & bus.rd_en;
    assign idx      = IDX_W'(bus.addr);
    assign cur_word = mem[idx];
    assign rd_word  = in_range ? cur_word : '0;

    // Merge strobed bytes into the current word so the array sees one whole-word write.
    always_comb begin
        wr_word = cur_word;
        for (int i = 0; i < NB; i++) begin
            if (bus.wstrb[i]) begin
                wr_word[8*i +: 8] = bus.wdata[8*i +: 8];
            end
        end
    end

    // Control FSM: clear sweep after reset, then run until the next reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_INIT;
            cnt     <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state)
                S_INIT: begin
                    if (cnt == LAST_IDX) begin
                        state   <= S_RUN;
                        ready_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    ready_q <= 1'b1;
                end
                default: begin
                    state   <= S_INIT;
                    cnt     <= '0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Storage has no reset; the sweep writes every word before ready rises.
    // Reads sample cur_word on the same edge, which gives read-first behaviour.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == S_INIT) begin
                mem[cnt] <= INIT_VAL;
            end else if (acc_wr && in_range) begin
                mem[idx] <= wr_word;
            end
        end
    end

`ifdef MEM_PARITY_EN
    assign cur_par   = par[idx];
    assign rd_perr_w = in_range ? (cur_par ^ byte_par(cur_word)) : '0;

    // Parity of each written byte is recomputed from wdata; par_inj flips it to model a fault.
    always_comb begin
        wr_par = cur_par;
        for (int i = 0; i < NB; i++) begin
            if (bus.wstrb[i]) begin
                wr_par[i] = (^bus.wdata[8*i +: 8]) ^ bus.par_inj;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == S_INIT) begin
                par[cnt] <= INIT_PAR;
            end else if (acc_wr && in_range) begin
                par[idx] <= wr_par;
            end
        end
    end
`endif

    // One addr_err pulse per accepted cycle, even when both read and write are out of range.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_err_q <= 1'b0;
        end else begin
            addr_err_q <= (acc_wr | acc_rd) & ~in_range;
        end
    end

    // Read pipeline. rdata only loads on a valid read so it holds between reads.
    if (RD_LAT == 2) begin : gen_lat2
        logic              s1_vld;
        logic [DATA_W-1:0] s1_dat;
`ifdef MEM_PARITY_EN
        logic [NB-1:0]     s1_perr;
`endif
        always_ff @(posedge clk) begin
            if (reset) begin
                s1_vld     <= 1'b0;
                s1_dat     <= '0;
                rd_valid_q <= 1'b0;
                rdata_q    <= '0;
`ifdef MEM_PARITY_EN
                s1_perr    <= '0;
                rd_perr_q  <= '0;
`endif
            end else begin
                s1_vld     <= acc_rd;
                rd_valid_q <= s1_vld;
                if (acc_rd) begin
                    s1_dat <= rd_word;
`ifdef MEM_PARITY_EN
                    s1_perr <= rd_perr_w;
`endif
                end
                if (s1_vld) begin
                    rdata_q <= s1_dat;
`ifdef MEM_PARITY_EN
                    rd_perr_q <= s1_perr;
`endif
                end
            end
        end
    end else begin : gen_lat1
        always_ff @(posedge clk) begin
            if (reset) begin
                rd_valid_q <= 1'b0;
                rdata_q    <= '0;
`ifdef MEM_PARITY_EN
                rd_perr_q  <= '0;
`endif
            end else begin
                rd_valid_q <= acc_rd;
                if (acc_rd) begin
                    rdata_q <= rd_word;
`ifdef MEM_PARITY_EN
                    rd_perr_q <= rd_perr_w;
`endif
                end
            end
        end
    end

    assign bus.rdata    = rdata_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.ready    = ready_q;
    assign bus.addr_err = addr_err_q;
`ifdef MEM_PARITY_EN
    assign bus.rd_perr  = rd_perr_q;
`endif

endmodule

// File: tb/tb_mem_bank_ctrl.sv
// Testbench for mem_bank_ctrl: two instances (RD_LAT 1 and 2) driven by the same directed vectors.
// Latency of each instance is checked through per-instance expected-output slots.
// Backpressure: vectors issued during the clear sweep are expected to be ignored.
module tb_mem_bank_ctrl;
    localparam int          DW    = 32;
    localparam int          DEPTH = 16;
    localparam int          AW    = 5;
    localparam logic [31:0] IV    = 32'hC0DE_0001;

    logic        clk = 1'b0;
    logic        reset;
    logic [AW-1:0] addr;
    logic        wr_en;
    logic        rd_en;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
`ifdef MEM_PARITY_EN
    logic        par_inj;
`endif

    always #5 clk = ~clk;

    mem_bank_if #(.DATA_W(DW), .ADDR_W(AW)) if1 ();
    mem_bank_if #(.DATA_W(DW), .ADDR_W(AW)) if2 ();

    assign if1.addr  = addr;  assign if2.addr  = addr;
    assign if1.wr_en = wr_en; assign if2.wr_en = wr_en;
    assign if1.rd_en = rd_en; assign if2.rd_en = rd_en;
    assign if1.wstrb = wstrb; assign if2.wstrb = wstrb;
    assign if1.wdata = wdata; assign if2.wdata = wdata;
`ifdef MEM_PARITY_EN
    assign if1.par_inj = par_inj; assign if2.par_inj = par_inj;
`endif

    mem_bank_ctrl #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .RD_LAT(1), .INIT_VAL(IV)) u_lat1 (
        .clk(clk), .reset(reset), .bus(if1.slave));
    mem_bank_ctrl #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .RD_LAT(2), .INIT_VAL(IV)) u_lat2 (
        .clk(clk), .reset(reset), .bus(if2.slave));

    logic [31:0] o_d [2];
    logic        o_v [2];
    logic        o_rdy [2];
    logic        o_err [2];
    assign o_d[0] = if1.rdata;    assign o_d[1] = if2.rdata;
    assign o_v[0] = if1.rd_valid; assign o_v[1] = if2.rd_valid;
    assign o_rdy[0] = if1.ready;  assign o_rdy[1] = if2.ready;
    assign o_err[0] = if1.addr_err; assign o_err[1] = if2.addr_err;
`ifdef MEM_PARITY_EN
    logic [3:0] o_p [2];
    assign o_p[0] = if1.rd_perr;  assign o_p[1] = if2.rd_perr;
`endif

    typedef struct {
        logic        wr;
        logic        rd;
        logic [4:0]  addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic        pinj;
        logic [31:0] exp_d;
        logic [3:0]  exp_perr;
        logic        exp_err;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int ready_at = 1 << 30;
    bit chk_en = 1'b0;

    // Expected outputs indexed by observation cycle modulo 8, per instance.
    bit          ev [2][8];
    logic [31:0] ed [2][8];
    logic [3:0]  ep [2][8];
    bit          ee [8];
    logic [31:0] last_d [2];

    function automatic vec_t mk(input logic wr, input logic rd, input logic [4:0] a,
                                input logic [3:0] st, input logic [31:0] wd,
                                input logic [31:0] exp_d, input logic exp_err,
                                input logic pinj, input logic [3:0] exp_perr);
        vec_t v;
        v.wr = wr; v.rd = rd; v.addr = a; v.wstrb = st; v.wdata = wd;
        v.exp_d = exp_d; v.exp_err = exp_err; v.pinj = pinj; v.exp_perr = exp_perr;
        return v;
    endfunction

    function automatic vec_t rd_v(input logic [4:0] a, input logic [31:0] exp_d, input logic err);
        return mk(1'b0, 1'b1, a, 4'h0, 32'h0, exp_d, err, 1'b0, 4'h0);
    endfunction

    function automatic vec_t wr_v(input logic [4:0] a, input logic [3:0] st, input logic [31:0] wd,
                                  input logic err);
        return mk(1'b1, 1'b0, a, st, wd, 32'h0, err, 1'b0, 4'h0);
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d: got %h, want %h", nm, cyc, act, exp);
        end
    endtask

    task automatic check();
        int s;
        s = cyc % 8;
        for (int i = 0; i < 2; i++) begin
            cmp($sformatf("ready[lat%0d]", i + 1), 32'(o_rdy[i]), 32'(cyc >= ready_at));
            cmp($sformatf("rd_valid[lat%0d]", i + 1), 32'(o_v[i]), 32'(ev[i][s]));
            if (ev[i][s]) begin
                cmp($sformatf("rdata[lat%0d]", i + 1), o_d[i], ed[i][s]);
                last_d[i] = ed[i][s];
`ifdef MEM_PARITY_EN
                cmp($sformatf("rd_perr[lat%0d]", i + 1), 32'(o_p[i]), 32'(ep[i][s]));
`endif
            end else begin
                cmp($sformatf("rdata_hold[lat%0d]", i + 1), o_d[i], last_d[i]);
            end
            cmp($sformatf("addr_err[lat%0d]", i + 1), 32'(o_err[i]), 32'(ee[s]));
            ev[i][s] = 1'b0;
        end
        ee[s] = 1'b0;
    endtask

    // One cycle: check what the previous edges produced, then drive the next request.
    task automatic step(input vec_t v, input bit rst);
        @(negedge clk);
        if (chk_en) check();
        reset = rst;
        wr_en = v.wr;
        rd_en = v.rd;
        addr  = v.addr;
        wstrb = v.wstrb;
        wdata = v.wdata;
`ifdef MEM_PARITY_EN
        par_inj = v.pinj;
`endif
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                for (int k = 0; k < 8; k++) ev[i][k] = 1'b0;
                last_d[i] = 32'h0;
            end
            for (int k = 0; k < 8; k++) ee[k] = 1'b0;
            ready_at = cyc + DEPTH + 1;
            chk_en   = 1'b1;
        end else if (chk_en && cyc >= ready_at) begin
            if (v.rd) begin
                for (int i = 0; i < 2; i++) begin
                    ev[i][(cyc + i + 1) % 8] = 1'b1;
                    ed[i][(cyc + i + 1) % 8] = v.exp_d;
                    ep[i][(cyc + i + 1) % 8] = v.exp_perr;
                end
            end
            if (v.exp_err) ee[(cyc + 1) % 8] = 1'b1;
        end
        cyc++;
    endtask

    initial begin
        vec_t idle;
        vec_t tbl[$];

        reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; addr = '0; wstrb = '0; wdata = '0;
`ifdef MEM_PARITY_EN
        par_inj = 1'b0;
`endif
        idle = mk(1'b0, 1'b0, 5'd0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0);

        // Word contents after the sequence below, hand-derived:
        // 3 = DE22BE44, 5 = 0F0F0F0F, 6 = ABDE0001, all others = INIT value.
        for (int a = 0; a < 16; a++) tbl.push_back(rd_v(5'(a), IV, 1'b0));
        tbl.push_back(wr_v(5'd3, 4'b1111, 32'hDEADBEEF, 1'b0));
        tbl.push_back(wr_v(5'd3, 4'b0101, 32'h11223344, 1'b0));
        tbl.push_back(rd_v(5'd3, 32'hDE22BE44, 1'b0));
        tbl.push_back(wr_v(5'd5, 4'b1111, 32'hA5A5A5A5, 1'b0));
        tbl.push_back(mk(1'b1, 1'b1, 5'd5, 4'b1111, 32'h0F0F0F0F, 32'hA5A5A5A5, 1'b0, 1'b0, 4'h0));
        tbl.push_back(rd_v(5'd5, 32'h0F0F0F0F, 1'b0));
        tbl.push_back(mk(1'b1, 1'b1, 5'd20, 4'b1111, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0, 4'h0));
        tbl.push_back(wr_v(5'd7, 4'b0000, 32'h12345678, 1'b0));
        tbl.push_back(wr_v(5'd6, 4'b1000, 32'hAB000000, 1'b0));
        tbl.push_back(rd_v(5'd16, 32'h0, 1'b1));
        tbl.push_back(wr_v(5'd31, 4'b1111, 32'h55555555, 1'b1));
        tbl.push_back(idle);
        for (int a = 0; a < 16; a++) begin
            logic [31:0] e;
            e = (a == 3) ? 32'hDE22BE44 : (a == 5) ? 32'h0F0F0F0F : (a == 6) ? 32'hABDE0001 : IV;
            tbl.push_back(rd_v(5'(a), e, 1'b0));
        end
`ifdef MEM_PARITY_EN
        tbl.push_back(mk(1'b1, 1'b0, 5'd2, 4'b0010, 32'h00005A00, 32'h0, 1'b0, 1'b1, 4'h0));
        tbl.push_back(mk(1'b0, 1'b1, 5'd2, 4'h0, 32'h0, 32'hC0DE5A01, 1'b0, 1'b0, 4'b0010));
        tbl.push_back(mk(1'b1, 1'b0, 5'd2, 4'b0010, 32'h00005A00, 32'h0, 1'b0, 1'b0, 4'h0));
        tbl.push_back(mk(1'b0, 1'b1, 5'd2, 4'h0, 32'h0, 32'hC0DE5A01, 1'b0, 1'b0, 4'b0000));
        tbl.push_back(mk(1'b0, 1'b1, 5'd20, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 4'b0000));
`endif

        // Reset, then requests during the sweep must be ignored (no rd_valid, no addr_err).
        step(idle, 1'b1);
        step(idle, 1'b1);
        for (int k = 0; k < DEPTH; k++) begin
            if (k < 2)      step(mk(1'b1, 1'b1, 5'd20, 4'hF, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0), 1'b0);
            else if (k < 4) step(mk(1'b1, 1'b1, 5'd3, 4'hF, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0), 1'b0);
            else            step(idle, 1'b0);
        end

        for (int i = 0; i < tbl.size(); i++) step(tbl[i], 1'b0);

        // Reset in the cycle after the second of four back-to-back reads is accepted.
        step(rd_v(5'd3, 32'hDE22BE44, 1'b0), 1'b0);
        step(rd_v(5'd3, 32'hDE22BE44, 1'b0), 1'b0);
        step(rd_v(5'd3, 32'hDE22BE44, 1'b0), 1'b1);
        step(rd_v(5'd3, 32'hDE22BE44, 1'b0), 1'b0);
        for (int k = 0; k < DEPTH - 1; k++) step(idle, 1'b0);
        step(rd_v(5'd3, IV, 1'b0), 1'b0);
        step(rd_v(5'd5, IV, 1'b0), 1'b0);
        for (int k = 0; k < 3; k++) step(idle, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_bank_ctrl.md
# mem_bank_ctrl

Parametrised single-clock memory bank: the next generation of the team's simple memory model. It generalises width and depth, adds per-byte write strobes, a configurable read pipeline with a valid flag, a post-reset clear sweep with a ready indication, and address range checking. It sits between a bus agent and storage and is driven through the existing memory interface style of signals.

## Interface
- DATA_W, 32: data width in bits; must be a multiple of 8.
- DEPTH, 16: number of words; need not be a power of 2.
- ADDR_W, $clog2(DEPTH): address width.
- RD_LAT, 1: read latency in cycles; legal values are 1 or 2.
- INIT_VAL, 0: DATA_W value written to every word by the clear sweep.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high.
- addr  in  ADDR_W  address shared by reads and writes.
- wr_en  in  1  write request.
- rd_en  in  1  read request.
- wstrb  in  DATA_W/8  byte write enables; bit i covers wdata[8i+7:8i].
- wdata  in  DATA_W  write data.
- rdata  out  DATA_W  read data; valid only while rd_valid is high.
- rd_valid  out  1  rdata qualifier; one pulse per accepted read.
- ready  out  1  high when requests are accepted.
- addr_err  out  1  one-cycle pulse when an accepted request has addr >= DEPTH.

## Operation
- FSM states:
  - INIT. Entered on reset. A counter sweeps 0..DEPTH-1, writing INIT_VAL to one word per cycle. ready = 0. After word DEPTH-1 is written, the FSM moves to RUN.
  - RUN. ready = 1. The FSM leaves RUN only on reset.
- Requests seen while ready = 0 are ignored and produce no rd_valid and no addr_err.
- Write in RUN: when wr_en = 1 and addr < DEPTH, each byte with its wstrb bit set is updated at the clock edge. Bytes with wstrb = 0 keep their value. wstrb = 0 makes the write a no-op, but it still counts as accepted.
- Read in RUN: when rd_en = 1 the read is accepted. Data appears RD_LAT cycles later with rd_valid = 1.
- Back-to-back reads are allowed every cycle, giving full throughput.
- Read and write in the same cycle:
  - Both are accepted.
  - The read is read-first: it returns the word as it was before that cycle's write, for the same address or a different one.
- Out of range (addr >= DEPTH):
  - Write is dropped.
  - Read returns rdata = 0 with rd_valid still pulsed.
  - addr_err pulses in the cycle after acceptance. A read and a write that are both out of range produce a single pulse.
- Reset mid-operation:
  - Reads in the pipeline are discarded and rd_valid goes to 0.
  - Memory contents are re-cleared by a new INIT sweep.

## Timing
- Reset values: rdata = 0, rd_valid = 0, ready = 0, addr_err = 0. The sweep counter is 0 and the FSM is in INIT.
- After reset deasserts, ready rises DEPTH cycles later. The first request is accepted in the first cycle with ready = 1.
- Read at edge N: rd_valid/rdata are valid after edge N+RD_LAT, for exactly one cycle per read.
- A write at edge N is visible to a read accepted at edge N+1.
- rdata holds its last value when rd_valid = 0. No X is allowed after reset.

## Configuration
- MEM_PARITY_EN defined:
  - One even-parity bit is stored per byte. Parity is updated together with that byte on every write and on the INIT sweep.
  - Extra input par_inj (1 bit): when high on a write, the stored parity of every written byte is inverted.
  - Extra output rd_perr (DATA_W/8 bits): valid with rd_valid and shows per-byte parity mismatch; reset value 0.
  - For out-of-range reads, rd_perr = 0.
- MEM_PARITY_EN undefined: no parity storage, no par_inj or rd_perr ports, and behaviour is otherwise identical.

## Test plan
- Reset, then idle with DEPTH = 16: ready rises 16 cycles after reset deasserts. Reads of addresses 0..15 each return INIT_VAL with one rd_valid per read.
- Write addr 3, wdata 0xDEADBEEF, wstrb 4'b1111. Then write addr 3, wdata 0x11223344, wstrb 4'b0101. A read of addr 3 returns 0xDE22BE44 with RD_LAT = 1 and with RD_LAT = 2.
- Read and write of addr 5 in the same cycle (old value 0xA5A5A5A5, wdata 0x0F0F0F0F): the read returns 0xA5A5A5A5 and the next read returns 0x0F0F0F0F.
- Write and read at addr 20 with DEPTH = 16: addr_err pulses once, the read returns 0 with rd_valid = 1, and words 0..15 are unchanged.
- Issue 4 back-to-back reads, then assert reset in the cycle after the second is accepted: no further rd_valid, ready = 0, and after re-init a read of a previously written word returns INIT_VAL.
- With MEM_PARITY_EN: write addr 2 with par_inj = 1 and wstrb 4'b0010. The read returns rd_perr = 4'b0010. A clean rewrite clears it to 0.
